// File: rtl/register.sv
// Generic N-bit state element: parallel load on enabled clock edges, asynchronous
// active-high reset to RST_VAL. Used for pipeline registers, PC and flag storage.
module register #(
    parameter int          N       = 32,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);

    // Storage flops: reset wins over enable, all N bits update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= RST_VAL;
        end else if (en) begin
            Q <= D;
        end else begin
            Q <= Q;
        end
    end

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: directed vector table, hand-written corner
// sequences, and randomized traffic against a cycle-level reference model.
module tb_register;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] d;
    logic [31:0] q;
    logic        rst8;
    logic        en8;
    logic [7:0]  d8;
    logic [7:0]  q8;

    int checks   = 0;
    int failures = 0;

    // Reference model state, updated from the spec rules rather than the RTL.
    logic [31:0] m32;
    logic [7:0]  m8;

    localparam logic [7:0] RST8 = 8'h5A;

    register #(.N(32)) dut (
        .clk(clk), .rst(rst), .en(en), .D(d), .Q(q)
    );

    register #(.N(8), .RST_VAL(8'h5A)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .D(d8), .Q(q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] d;
        logic [31:0] q_before;
        logic [31:0] q_after;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle on both instances: drive after a falling edge, check the
    // pre-edge value (async reset visible at once, no D/en path), then post-edge.
    task automatic step(input logic r, input logic e, input logic [31:0] dv,
                        input logic r8, input logic e8, input logic [7:0] dv8,
                        input string tag);
        @(negedge clk);
        rst = r; en = e; d = dv;
        rst8 = r8; en8 = e8; d8 = dv8;
        if (r)  m32 = 32'h0;
        if (r8) m8  = RST8;
        #1;
        check({tag, "_before"},   q,         m32);
        check({tag, "_before8"},  {24'h0, q8}, {24'h0, m8});
        @(posedge clk);
        if (r)       m32 = 32'h0;
        else if (e)  m32 = dv;
        if (r8)      m8  = RST8;
        else if (e8) m8  = dv8;
        #1;
        check({tag, "_after"},    q,         m32);
        check({tag, "_after8"},   {24'h0, q8}, {24'h0, m8});
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b1, 32'hE1A020A2, 32'h00000000, 32'hE1A020A2};
        vecs[2]  = '{1'b0, 1'b1, 32'hAA000004, 32'hE1A020A2, 32'hAA000004};
        vecs[3]  = '{1'b1, 1'b0, 32'hAA000004, 32'h00000000, 32'h00000000};
        vecs[4]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        vecs[5]  = '{1'b0, 1'b0, 32'hE1A020A2, 32'h00000000, 32'h00000000};
        vecs[6]  = '{1'b0, 1'b0, 32'hE1A020A2, 32'h00000000, 32'h00000000};
        vecs[7]  = '{1'b0, 1'b1, 32'h5555AAAA, 32'h00000000, 32'h5555AAAA};
        vecs[8]  = '{1'b0, 1'b0, 32'h00000000, 32'h5555AAAA, 32'h5555AAAA};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h5555AAAA, 32'hFFFFFFFF};
        vecs[10] = '{1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[11] = '{1'b0, 1'b1, 32'h80000001, 32'h00000000, 32'h80000001};

        rst = 1'b1; en = 1'b0; d = $urandom;
        rst8 = 1'b1; en8 = 1'b1; d8 = 8'hFF;
        m32 = 32'h0; m8 = RST8;
        #1;
        check("reset_async",  q, 32'h00000000);
        check("reset_async8", {24'h0, q8}, {24'h0, RST8});
        @(posedge clk); #1;
        check("reset_edge",   q, 32'h00000000);
        check("rst_vs_en8",   {24'h0, q8}, {24'h0, RST8});

        // Directed table on the 32-bit instance.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; en = vecs[i].en; d = vecs[i].d;
            #1;
            check($sformatf("vec%0d_before", i), q, vecs[i].q_before);
            @(posedge clk); #1;
            check($sformatf("vec%0d_after", i), q, vecs[i].q_after);
        end
        m32 = vecs[11].q_after;

        // D toggling between edges with en=0 and en=1 must not reach Q early.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; d = 32'h12345678;
        @(posedge clk); #1;
        m32 = 32'h12345678;
        check("load_mid", q, m32);
        d = 32'hCAFEF00D; #2;
        check("d_change_no_effect", q, m32);
        en = 1'b0; #1;
        check("en_drop_no_effect", q, m32);
        @(posedge clk); #1;
        check("hold_after_d_change", q, m32);

        // Reset rising exactly with an enabled clock edge discards the load.
        @(negedge clk);
        en = 1'b1; d = 32'h0F0F0F0F;
        en8 = 1'b1; rst8 = 1'b0; d8 = 8'h33;
        @(posedge clk);
        rst = 1'b1; rst8 = 1'b1;
        #1;
        m32 = 32'h0; m8 = RST8;
        check("coincident_reset",  q, 32'h00000000);
        check("coincident_reset8", {24'h0, q8}, {24'h0, RST8});
        @(posedge clk); #1;
        check("reset_held", q, 32'h00000000);

        // Release reset with en=0: reset value persists until an enabled edge.
        step(1'b0, 1'b0, 32'h76543210, 1'b0, 1'b0, 8'hC3, "release_hold");
        step(1'b0, 1'b1, 32'h76543210, 1'b0, 1'b1, 8'hC3, "first_load");

        // Randomized traffic against the model on both instances.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom,
                 ($urandom_range(0, 15) == 0), $urandom_range(0, 1), 8'($urandom),
                 $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
